// File: rtl/seq_scan_multi_if.sv
// Symbol stream, pattern configuration and result bundle for seq_scan_multi.
// The scanner connects through the slave modport and its driver through the master modport.
interface seq_scan_multi_if #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 5,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter int IDW     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
);
  logic                       in_valid;
  logic [SYM_W-1:0]           in_sym;
  logic                       mode_ovl;
  logic                       cfg_we;
  logic [IDW-1:0]             cfg_idx;
  logic                       cfg_en;
  logic [SEQ_LEN*SYM_W-1:0]   cfg_pat;
  logic                       cnt_clr;
  logic                       match;
  logic [IDW-1:0]             match_id;
  logic [NUM_PAT-1:0]         match_vec;
  logic [NUM_PAT*CNT_W-1:0]   hit_cnt;

  modport master (
    output in_valid, in_sym, mode_ovl, cfg_we, cfg_idx, cfg_en, cfg_pat, cnt_clr,
    input  match, match_id, match_vec, hit_cnt
  );

  modport slave (
    input  in_valid, in_sym, mode_ovl, cfg_we, cfg_idx, cfg_en, cfg_pat, cnt_clr,
    output match, match_id, match_vec, hit_cnt
  );
endinterface

// File: rtl/seq_scan_multi.sv
// Compares the last SEQ_LEN accepted symbols against NUM_PAT programmable patterns,
// producing a registered match pulse and per-slot saturating hit counters.
module seq_scan_multi #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 5,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter int IDW     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  seq_scan_multi_if.slave bus
);
  localparam int HW = SEQ_LEN * SYM_W;
  localparam int FW = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [HW-1:0]                 hist_q, hist_d, hist_nx_s;
  logic [FW-1:0]                 fill_q, fill_d, fill_inc_s;
  logic [NUM_PAT-1:0][HW-1:0]    pat_q, pat_d;
  logic [NUM_PAT-1:0]            en_q, en_d;
  logic [NUM_PAT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_PAT-1:0]            hit_s;
  logic                          match_q, match_d;
  logic [IDW-1:0]                match_id_q, match_id_d;
  logic [NUM_PAT-1:0]            match_vec_q, match_vec_d;

  // Hit detection against the history as it will look after this symbol; oldest symbol sits in the low bits.
  always_comb begin
    hist_nx_s  = {bus.in_sym, hist_q[HW-1:SYM_W]};
    fill_inc_s = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    hit_s      = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      hit_s[k] = bus.in_valid && en_q[k] && (fill_inc_s == FILL_FULL) &&
                 (hist_nx_s == pat_q[k]) &&
                 !(bus.cfg_we && (bus.cfg_idx == IDW'(k)));
    end
  end

  // History, fill, slot configuration and counter next-state.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    en_d   = en_q;
    cnt_d  = cnt_q;
    if (bus.in_valid) begin
      hist_d = hist_nx_s;
      fill_d = ((|hit_s) && !bus.mode_ovl) ? '0 : fill_inc_s;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    for (int k = 0; k < NUM_PAT; k++) begin
      if (bus.cfg_we && (bus.cfg_idx == IDW'(k))) begin
        pat_d[k] = bus.cfg_pat;
        en_d[k]  = bus.cfg_en;
      end else begin
        pat_d[k] = pat_q[k];
        en_d[k]  = en_q[k];
      end
      if (bus.cnt_clr) begin
        cnt_d[k] = '0;
      end else if (hit_s[k] && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Result next-state; scanning downward leaves the lowest hitting index.
  always_comb begin
    match_d     = |hit_s;
    match_vec_d = hit_s;
    match_id_d  = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      match_id_d = hit_s[k] ? IDW'(k) : match_id_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q      <= '0;
      fill_q      <= '0;
      pat_q       <= '0;
      en_q        <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      match_id_q  <= '0;
      match_vec_q <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      pat_q       <= pat_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      match_id_q  <= match_id_d;
      match_vec_q <= match_vec_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_id  = match_id_q;
  assign bus.match_vec = match_vec_q;
  assign bus.hit_cnt   = cnt_q;
endmodule

// File: doc/seq_scan_multi.md
# seq_scan_multi

Parametrised multi-pattern symbol sequence scanner for the serial symbol front end. It accepts a qualified stream of SYM_W-bit symbols and compares the most recent SEQ_LEN accepted symbols against NUM_PAT run-time programmable patterns. On each hit it raises a registered match pulse and increments a per-pattern saturating hit counter. Overlapping and restart-after-match detection are both supported, selected by a mode input.

## Interface
Parameters:
- SYM_W, 2, symbol width in bits.
- SEQ_LEN, 5, pattern length in symbols (≥2).
- NUM_PAT, 2, number of pattern slots (≥1).
- CNT_W, 8, hit counter width.
- IDW, max(1,$clog2(NUM_PAT)), pattern index width.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  in  1  symbol qualifier; a symbol is accepted on a rising edge where in_valid=1.
- in_sym  in  SYM_W  input symbol.
- mode_ovl  in  1  1 = overlapping detection, 0 = restart after match.
- cfg_we  in  1  pattern slot write strobe.
- cfg_idx  in  IDW  slot written.
- cfg_en  in  1  enable bit written with the slot.
- cfg_pat  in  SEQ_LEN*SYM_W  pattern; bits [SYM_W-1:0] hold the oldest (first) symbol.
- cnt_clr  in  1  synchronous clear of all hit counters.
- match  out  1  one-cycle hit pulse.
- match_id  out  IDW  lowest-index slot hit; valid while match=1.
- match_vec  out  NUM_PAT  per-slot hit flags.
- hit_cnt  out  NUM_PAT*CNT_W  per-slot counters; slot k occupies [k*CNT_W +: CNT_W].

## Operation
- History: SEQ_LEN-deep shift register of accepted symbols plus a fill counter (0..SEQ_LEN, saturating). Each accepted symbol shifts in as the newest entry. Cycles with in_valid=0 change nothing.
- Compare: on each accepted symbol, form next-history = old history shifted with in_sym. Slot k hits when it is enabled, fill_next ≥ SEQ_LEN, and next-history equals pat[k].
- Mode:
  - mode_ovl=1: history and fill continue after a hit, so overlapping occurrences are each detected.
  - mode_ovl=0: any hit resets fill to 0. The next hit needs SEQ_LEN fresh symbols.
  - Mode is sampled per accepted symbol.
- Multiple hits in one cycle:
  - match_vec shows every hitting slot.
  - match_id is the lowest hitting index.
  - Every hitting slot's counter increments.
- Counters:
  - Each counter increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 zeroes all counters and takes priority over a same-cycle increment.
- Configuration write (cfg_we=1, cfg_idx<NUM_PAT):
  - Loads pat[cfg_idx] and en[cfg_idx].
  - The written slot is masked from comparison in the write cycle. The new contents apply from the next accepted symbol.
  - History, fill and counters are not affected.
  - A write with cfg_idx ≥ NUM_PAT is ignored.
- Reset (rst=0, any time, including mid-stream):
  - History, fill and counters go to 0.
  - All slots are disabled, with pattern contents 0.
  - match=0, match_id=0, match_vec=0.
  - The in-progress partial sequence is lost; no match is produced for it.

## Timing
- Latency 1 cycle: a symbol accepted at edge N that completes a hit gives match=1 for the cycle after edge N. match deasserts at edge N+1 unless that edge also produces a hit.
- Consecutive hits on back-to-back accepted symbols (overlap mode) keep match high continuously; each cycle counts separately.
- hit_cnt updates at the same edge that raises match.
- Outputs are all registered; no combinational path from input to output.
- Reset release is asynchronous to clk; the first symbol is accepted at the first rising edge with rst=1 and in_valid=1.

## Test plan
- Defaults, slot0=(0,1,3,2,0), slot1=(0,2,3,1,0), both enabled, mode_ovl=0; stream 0,1,3,2,0 with in_valid=1 -> match=1, match_id=0, match_vec=01 in the cycle after the last 0; hit_cnt slot0=1.
- Overlap: slot0=(0,1,0), SEQ_LEN=3, stream 0,1,0,1,0 -> mode_ovl=1 gives 2 pulses (after symbols 3 and 5); mode_ovl=0 gives 1 pulse (after symbol 3).
- in_valid gaps: 0,1,3,2,0 with in_valid=0 cycles (in_sym=3) interleaved -> same single hit; idle cycles ignored.
- Simultaneous hit and saturation:
  - Two slots programmed identical -> match_vec=11, match_id=0, both counters increment.
  - With CNT_W=2 after 5 hits -> counters read 3.
  - cnt_clr asserted on a hit edge -> counters read 0.
- Config and reset:
  - A write to slot0 in the same cycle its old pattern completes -> no hit.
  - Assert rst after 0,1,3 -> all outputs 0 asynchronously.
  - After release, feeding 2,0 gives no hit; a full fresh sequence is required.
